mips_run_ctrl: RTL
==================

# mips_run_ctrl

Run controller for the single-cycle MIPS core. It streams a program image into instruction memory while the core is held in reset, then releases the core and runs it until the PC reaches a halt address or a cycle limit expires. It then freezes the core and scans all 32 registers out over a valid/ready dump port. It replaces open-loop fixed-delay benches with a deterministic, cycle-counted run/inspect sequence and sits between the bench or host link and the `MIPS` top.

## Interface
Parameters:
- IM_DEPTH, 256: instruction memory depth in words; IM_AW = clog2(IM_DEPTH)
- CYC_W, 16: width of cycle counter and limit

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  program word offered
- load_data  in  32  program word
- load_ready  out  1  word accepted when load_valid & load_ready
- start  in  1  begin run (level, sampled per cycle)
- halt_pc  in  32  PC value that ends the run
- cycle_limit  in  CYC_W  maximum instructions executed
- im_we  out  1  IM write strobe
- im_waddr  out  IM_AW  IM word address
- im_wdata  out  32  IM write data
- cpu_rst  out  1  core reset hold
- cpu_run  out  1  core clock enable
- cpu_pc  in  32  core PC
- rf_raddr  out  5  RF debug read address (async read)
- rf_rdata  in  32  RF debug read data
- dump_valid  out  1  register dump beat valid
- dump_idx  out  5  register index of beat
- dump_data  out  32  register value
- dump_ready  in  1  dump beat consumed
- busy  out  1  state is RSTCPU, RUN or DUMP
- done  out  1  dump complete
- timeout  out  1  run ended on cycle_limit
- cycles  out  CYC_W  instructions executed in last run

## Operation
- States: IDLE, RSTCPU, RUN, DUMP, DONE.
- IDLE/DONE:
  - load_ready = (wptr != IM_DEPTH).
  - Accepted word: im_we=1 same cycle, im_waddr=wptr, im_wdata=load_data, wptr++.
  - wptr==IM_DEPTH: load_ready=0 (full); no wrap.
  - DONE→IDLE on the first accepted word; wptr was cleared to 0 on DONE entry.
- start in IDLE or DONE → RSTCPU. A word accepted in the same cycle is still written. cycles←0, timeout←0, done←0.
- RSTCPU: 2 cycles, cpu_rst=1, then RUN.
- RUN:
  - cpu_run = (cpu_pc != halt_pc) && (cycles != cycle_limit), combinational.
  - cycles++ each cycle cpu_run=1.
  - When cpu_run=0 → DUMP; timeout←1 if cycles==cycle_limit and cpu_pc!=halt_pc.
  - The instruction at halt_pc is never executed.
- DUMP:
  - cpu_run=0, cpu_rst=0; core state frozen.
  - dump_valid=1, rf_raddr=dump_idx, dump_data=rf_rdata.
  - idx advances on dump_valid&dump_ready; beat idx 31 accepted → DONE.
- DONE: done=1, core frozen. A new start reruns the retained IM image.
- cpu_rst=1 in IDLE, RSTCPU and DONE-after-load (any state except RUN, DUMP, DONE); 0 otherwise.
- cycles and timeout hold their values through DUMP and DONE.

## Timing
- Reset values: state IDLE, wptr 0, cycles 0, idx 0, timeout 0, done 0, busy 0, dump_valid 0, im_we 0, cpu_run 0, cpu_rst 1, load_ready 1.
- Reset mid-operation (any state): IDLE next cycle. IM contents untouched; dump aborted with no further beats.
- Latencies:
  - start sampled at edge N → RSTCPU from N+1.
  - First cpu_run=1 at N+3.
  - RUN exit → dump_valid=1 on the next cycle.
  - Dump takes ≥32 cycles; backpressure holds idx and data stable.
- cycle_limit==0: RUN lasts one cycle, cpu_run=0, timeout=1, cycles=0.
- halt_pc==0: no instruction runs, timeout=0.
- halt_pc and cycle_limit must stay stable while busy. start and load are ignored while busy.

## Structure
- Package mips_run_pkg: state enum, NUM_REGS=32, RSTCPU_CYCLES=2.
- Sub-module rf_dump_seq: idx counter plus valid/ready logic, with go in and last out.
- Top module holds the FSM, the load pointer and the cycle counter.

## Test plan
- Load 4 words (`0x20080005`, `0x20090003`, `0x01095020`, `0x08000003`), halt_pc=`0x0C`, limit=100, start → cpu_run high 3 cycles, cycles=3, timeout=0, dump beat 10 = `0x00000008`, done=1.
- Same image with halt_pc=`0x40` and limit=20 → timeout=1, cycles=20, 32 dump beats.
- Stream IM_DEPTH+1 words → load_ready=0 after word IM_DEPTH; last word never written; wptr does not wrap.
- Random dump_ready backpressure → dump_idx 0..31 in order, no gaps or duplicates, data stable while stalled.
- Assert reset mid-RUN → IDLE next cycle, cpu_rst=1, cpu_run=0. A following start reruns the retained image and produces identical dump results.
- cycle_limit=0 → timeout=1, cycles=0, dump shows post-reset register values.

Source files
------------

// File: rtl/mips_run_pkg.sv
// Shared definitions for the MIPS run controller.
//   run_state_e   : controller FSM states (also visible on the dbg_state port)
//   NUM_REGS      : register file entries scanned out after a run
//   RSTCPU_CYCLES : cycles the core is held in reset before it is released
package mips_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RSTCPU = 3'd1,
    ST_RUN    = 3'd2,
    ST_DUMP   = 3'd3,
    ST_DONE   = 3'd4
  } run_state_e;

  localparam int NUM_REGS      = 32;
  localparam int RSTCPU_CYCLES = 2;

endpackage

// File: rtl/mips_run_ctrl_rf_dump_seq.sv
// Register dump sequencer: walks register indices 0..NUM_REGS-1 over a
// valid/ready port once it is kicked by go.
//   clk, reset  : clock and synchronous active-high reset
//   go          : one-cycle pulse, arms the dump starting at index 0
//   dump_ready  : consumer accepts the current beat
//   dump_valid  : beat on offer
//   dump_idx    : register index of the beat on offer
//   last        : the final beat is being accepted this cycle
//
// Handshake: a beat transfers on a rising edge where dump_valid & dump_ready
// are both high; while dump_valid is high and dump_ready is low, dump_idx
// (and therefore the data it addresses) holds steady.
module rf_dump_seq
  import mips_run_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       dump_ready,
  output logic       dump_valid,
  output logic [4:0] dump_idx,
  output logic       last
);

  logic       valid_q, valid_d;
  logic [4:0] idx_q, idx_d;
  logic       beat;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    beat    = valid_q & dump_ready;
    last    = beat && (idx_q == 5'(NUM_REGS - 1));
    if (go) begin
      valid_d = 1'b1;
      idx_d   = 5'd0;
    end else if (beat) begin
      if (last) begin
        valid_d = 1'b0;
        idx_d   = 5'd0;
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      idx_q   <= 5'd0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core. Streams a program image
// into instruction memory, holds then releases the core, runs it until the
// PC hits halt_pc or cycle_limit instructions have executed, then freezes
// the core and scans the register file out on the dump port.
//   load_*      : program word stream (valid/ready), accepted in IDLE/DONE
//   start       : begin a run (level, sampled each cycle in IDLE/DONE)
//   halt_pc     : PC whose instruction ends the run without executing
//   cycle_limit : maximum instructions executed per run
//   im_*        : instruction memory write port
//   cpu_rst     : core reset hold; cpu_run: core clock enable
//   cpu_pc      : core PC; rf_raddr/rf_rdata: async RF debug read
//   dump_*      : register dump beats (valid/ready)
//   busy/done/timeout/cycles : run status
//   dbg_state   : current FSM state
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both high; an offered beat's payload is held while
// ready is low.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter  int IM_DEPTH = 256,
  parameter  int CYC_W    = 16,
  localparam int IM_AW    = $clog2(IM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  output logic             load_ready,
  input  logic             start,
  input  logic [31:0]      halt_pc,
  input  logic [CYC_W-1:0] cycle_limit,
  output logic             im_we,
  output logic [IM_AW-1:0] im_waddr,
  output logic [31:0]      im_wdata,
  output logic             cpu_rst,
  output logic             cpu_run,
  input  logic [31:0]      cpu_pc,
  output logic [4:0]       rf_raddr,
  input  logic [31:0]      rf_rdata,
  output logic             dump_valid,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  input  logic             dump_ready,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles,
  output logic [2:0]       dbg_state
);

  run_state_e       state_q, state_d;
  logic [IM_AW:0]   wptr_q, wptr_d;     // one extra bit so "full" is representable
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       rst_cnt_q, rst_cnt_d;

  logic dump_go;
  logic dump_last;
  logic at_halt;
  logic at_limit;

  assign at_halt  = (cpu_pc == halt_pc);
  assign at_limit = (cycles_q == cycle_limit);

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cycles_d   = cycles_q;
    timeout_d  = timeout_q;
    rst_cnt_d  = rst_cnt_q;
    load_ready = 1'b0;
    im_we      = 1'b0;
    im_waddr   = wptr_q[IM_AW-1:0];
    im_wdata   = load_data;
    cpu_rst    = 1'b0;
    cpu_run    = 1'b0;
    dump_go    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        load_ready = (wptr_q != (IM_AW+1)'(IM_DEPTH));
        im_we      = load_valid & load_ready;
        // DONE keeps the core frozen so its registers stay inspectable until
        // the image is touched again.
        cpu_rst    = (state_q == ST_IDLE);
        if (im_we) begin
          wptr_d = wptr_q + 1'b1;
          if (state_q == ST_DONE) state_d = ST_IDLE;
        end
        // start takes priority over the DONE->IDLE move; a word offered in
        // the same cycle has already been written above.
        if (start) begin
          state_d   = ST_RSTCPU;
          cycles_d  = '0;
          timeout_d = 1'b0;
          rst_cnt_d = 2'd0;
        end
      end
      ST_RSTCPU: begin
        cpu_rst = 1'b1;
        if (rst_cnt_q == 2'(RSTCPU_CYCLES - 1)) state_d = ST_RUN;
        else rst_cnt_d = rst_cnt_q + 2'd1;
      end
      ST_RUN: begin
        // Gate the enable combinationally so the halt instruction never
        // gets a clock.
        cpu_run = !at_halt && !at_limit;
        if (cpu_run) begin
          cycles_d = cycles_q + CYC_W'(1);
        end else begin
          state_d   = ST_DUMP;
          dump_go   = 1'b1;
          timeout_d = at_limit && !at_halt;
        end
      end
      ST_DUMP: begin
        if (dump_last) begin
          state_d = ST_DONE;
          wptr_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      cycles_q  <= '0;
      timeout_q <= 1'b0;
      rst_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      cycles_q  <= cycles_d;
      timeout_q <= timeout_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  rf_dump_seq u_dump (
    .clk        (clk),
    .reset      (reset),
    .go         (dump_go),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .last       (dump_last)
  );

  assign rf_raddr  = dump_idx;
  assign dump_data = rf_rdata;
  assign busy      = (state_q == ST_RSTCPU) || (state_q == ST_RUN) || (state_q == ST_DUMP);
  assign done      = (state_q == ST_DONE);
  assign timeout   = timeout_q;
  assign cycles    = cycles_q;
  assign dbg_state = state_q;

endmodule
